plugboard_config_ctrl: RTL and testbench

- Sequencing and configuration controller for the Enigma plugboard.
- Accepts letter-pair entries from the keyboard/switch front end, validates them, and stores up to MAX_PAIRS symmetric swaps in a 26-entry partner map.
- Serves two read-only lookup ports: front, before the rotor/reflector stage, and rear, after it, before the GUI.
- Replaces ad-hoc combinational plugboard logic with a clocked, resettable table.

---
 rtl/enigma_pkg.sv | 27 ++
 rtl/onehot_to_idx.sv | 28 ++
 rtl/plugboard_config_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_plugboard_config_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/enigma_pkg.sv
// Shared types and constants for the Enigma plugboard configuration controller.
package enigma_pkg;

    localparam int LETTERS   = 26;
    localparam int IDX_W     = 5;
    localparam int MAX_PAIRS = 10;
    localparam int COUNT_W   = 4;

    typedef logic [LETTERS-1:0] letter_t;
    typedef logic [IDX_W-1:0]   idx_t;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_ONEHOT  = 3'd1,
        ERR_PLUGGED = 3'd2,
        ERR_SAME    = 3'd3,
        ERR_FULL    = 3'd4
    } err_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FIRST  = 2'd1,
        S_COMMIT = 2'd2,
        S_CLEAR  = 2'd3
    } state_t;

endpackage

// File: rtl/onehot_to_idx.sv
// Converts a 26-bit one-hot letter to its 5-bit index and flags whether the
// input really was one-hot (zero and multi-hot inputs give o_onehot_ok = 0).
module onehot_to_idx
    import enigma_pkg::*;
(
    input  letter_t    i_onehot,
    output idx_t       o_idx,
    output logic       o_onehot_ok
);

    logic [IDX_W-1:0] w_count;

    // OR together the positions of all set bits and count how many are set.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        o_idx   = '0;
        w_count = '0;
        for (int i = 0; i < LETTERS; i++) begin
            if (i_onehot[i]) begin
                o_idx   = o_idx | idx_t'(i);
                w_count = w_count + 1'b1;
            end
        end
    end

    assign o_onehot_ok = (w_count == IDX_W'(1));

endmodule

// File: rtl/plugboard_config_ctrl.sv
// Enigma plugboard configuration controller: validates letter-pair entries,
// keeps a 26-entry symmetric partner map and serves two registered lookups.
module plugboard_config_ctrl
    import enigma_pkg::*;
(
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               cfg_mode,
    input  logic               clear,
    input  logic [LETTERS-1:0] letter_in,
    input  logic               letter_valid,
    output logic               busy,
    output logic [LETTERS-1:0] pending_letter,
    output logic [COUNT_W-1:0] pair_count,
    output logic               pair_done,
    output logic               err_valid,
    output logic [2:0]         err_code,
    input  logic [LETTERS-1:0] fwd_in,
    output logic [LETTERS-1:0] fwd_out,
    input  logic [LETTERS-1:0] rev_in,
    output logic [LETTERS-1:0] rev_out
);

    // Partner map: identity entry means the letter is unplugged.
    idx_t               r_map [LETTERS];

    state_t             r_state;
    idx_t               r_first;
    idx_t               r_second;
    idx_t               r_sweep;
    logic [COUNT_W-1:0] r_pair_count;
    letter_t            r_pending;
    logic               r_busy;
    logic               r_pair_done;
    logic               r_err_valid;
    err_t               r_err_code;
    letter_t            r_fwd_out;
    letter_t            r_rev_out;

    idx_t               w_in_idx;
    logic               w_in_ok;
    idx_t               w_fwd_idx;
    logic               w_fwd_ok;
    idx_t               w_rev_idx;
    logic               w_rev_ok;
    logic               w_in_plugged;
    logic               w_full;
    err_t               w_idle_err;
    err_t               w_first_err;
    idx_t               w_fwd_part;
    idx_t               w_rev_part;

    onehot_to_idx u_entry_dec (
        .i_onehot    (letter_in),
        .o_idx       (w_in_idx),
        .o_onehot_ok (w_in_ok)
    );

    onehot_to_idx u_fwd_dec (
        .i_onehot    (fwd_in),
        .o_idx       (w_fwd_idx),
        .o_onehot_ok (w_fwd_ok)
    );

    onehot_to_idx u_rev_dec (
        .i_onehot    (rev_in),
        .o_idx       (w_rev_idx),
        .o_onehot_ok (w_rev_ok)
    );

    assign w_full = (r_pair_count == COUNT_W'(MAX_PAIRS));

    // Classify the entered letter; the map is only indexed when the index is valid.
    always_comb begin
        w_in_plugged = 1'b0;
        if (w_in_ok) begin
            w_in_plugged = (r_map[w_in_idx] != w_in_idx);
        end

        w_idle_err = ERR_NONE;
        if (!w_in_ok) begin
            w_idle_err = ERR_ONEHOT;
        end else if (w_full) begin
            w_idle_err = ERR_FULL;
        end else if (w_in_plugged) begin
            w_idle_err = ERR_PLUGGED;
        end

        w_first_err = ERR_NONE;
        if (!w_in_ok) begin
            w_first_err = ERR_ONEHOT;
        end else if (w_in_idx == r_first) begin
            w_first_err = ERR_SAME;
        end else if (w_in_plugged) begin
            w_first_err = ERR_PLUGGED;
        end
    end

    // Fetch partner indices for the two lookup ports; invalid inputs fetch nothing.
    always_comb begin
        w_fwd_part = '0;
        w_rev_part = '0;
        if (w_fwd_ok) begin
            w_fwd_part = r_map[w_fwd_idx];
        end
        if (w_rev_ok) begin
            w_rev_part = r_map[w_rev_idx];
        end
    end

    // Entry/commit/clear sequencer; owns the partner map and all status outputs.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            // NOTE: the map is a flop array, not a RAM, because reset must restore identity for every letter in a single cycle.
            for (int i = 0; i < LETTERS; i++) begin
                r_map[i] <= idx_t'(i);
            end
            r_state      <= S_IDLE;
            r_first      <= '0;
            r_second     <= '0;
            r_sweep      <= '0;
            r_pair_count <= '0;
            r_pending    <= '0;
            r_busy       <= 1'b0;
            r_pair_done  <= 1'b0;
            r_err_valid  <= 1'b0;
            r_err_code   <= ERR_NONE;
        end else begin
            // NOTE: non-blocking assignments everywhere here, so every branch reads the pre-edge state.
            r_pair_done <= 1'b0;
            r_err_valid <= 1'b0;

            if (clear && (r_state != S_CLEAR)) begin
                r_state    <= S_CLEAR;
                r_sweep    <= '0;
                r_busy     <= 1'b1;
                r_pending  <= '0;
                r_err_code <= ERR_NONE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (letter_valid && cfg_mode) begin
                            if (w_idle_err != ERR_NONE) begin
                                r_err_valid <= 1'b1;
                                r_err_code  <= w_idle_err;
                            end else begin
                                r_first   <= w_in_idx;
                                r_pending <= letter_in;
                                r_state   <= S_FIRST;
                            end
                        end
                    end

                    S_FIRST: begin
                        if (!cfg_mode) begin
                            r_pending <= '0;
                            r_state   <= S_IDLE;
                        end else if (letter_valid) begin
                            if (w_first_err != ERR_NONE) begin
                                r_err_valid <= 1'b1;
                                r_err_code  <= w_first_err;
                                r_pending   <= '0;
                                r_state     <= S_IDLE;
                            end else begin
                                r_second    <= w_in_idx;
                                r_busy      <= 1'b1;
                                r_pair_done <= 1'b1;
                                r_state     <= S_COMMIT;
                            end
                        end
                    end

                    S_COMMIT: begin
                        r_map[r_first]  <= r_second;
                        r_map[r_second] <= r_first;
                        r_pair_count    <= r_pair_count + 1'b1;
                        r_pending       <= '0;
                        r_busy          <= 1'b0;
                        r_state         <= S_IDLE;
                    end

                    S_CLEAR: begin
                        r_map[r_sweep] <= r_sweep;
                        if (r_sweep == idx_t'(LETTERS - 1)) begin
                            r_pair_count <= '0;
                            r_busy       <= 1'b0;
                            r_state      <= S_IDLE;
                        end else begin
                            r_sweep <= r_sweep + 1'b1;
                        end
                    end

                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Registered one-hot images of the two lookups, independent of the sequencer.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_fwd_out <= '0;
            r_rev_out <= '0;
        end else begin
            r_fwd_out <= w_fwd_ok ? (letter_t'(1) << w_fwd_part) : '0;
            r_rev_out <= w_rev_ok ? (letter_t'(1) << w_rev_part) : '0;
        end
    end

    assign busy           = r_busy;
    assign pending_letter = r_pending;
    assign pair_count     = r_pair_count;
    assign pair_done      = r_pair_done;
    assign err_valid      = r_err_valid;
    assign err_code       = r_err_code;
    assign fwd_out        = r_fwd_out;
    assign rev_out        = r_rev_out;

endmodule

// File: tb/tb_plugboard_config_ctrl.sv
// Directed bench for plugboard_config_ctrl with a scoreboard of expected
// errors, commits and lookup images.
module tb_plugboard_config_ctrl;

    localparam int E_ONEHOT  = 1;
    localparam int E_PLUGGED = 2;
    localparam int E_SAME    = 3;
    localparam int E_FULL    = 4;

    logic        CLOCK_50;
    logic        reset;
    logic        cfg_mode;
    logic        clear;
    logic [25:0] letter_in;
    logic        letter_valid;
    logic        busy;
    logic [25:0] pending_letter;
    logic [3:0]  pair_count;
    logic        pair_done;
    logic        err_valid;
    logic [2:0]  err_code;
    logic [25:0] fwd_in;
    logic [25:0] fwd_out;
    logic [25:0] rev_in;
    logic [25:0] rev_out;

    int n_pass  = 0;
    int n_total = 0;
    int exp_count = 0;

    int          err_q [$];
    int          pd_q  [$];
    logic [25:0] fwd_q [$];
    logic [25:0] rev_q [$];

    plugboard_config_ctrl dut (
        .CLOCK_50       (CLOCK_50),
        .reset          (reset),
        .cfg_mode       (cfg_mode),
        .clear          (clear),
        .letter_in      (letter_in),
        .letter_valid   (letter_valid),
        .busy           (busy),
        .pending_letter (pending_letter),
        .pair_count     (pair_count),
        .pair_done      (pair_done),
        .err_valid      (err_valid),
        .err_code       (err_code),
        .fwd_in         (fwd_in),
        .fwd_out        (fwd_out),
        .rev_in         (rev_in),
        .rev_out        (rev_out)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    initial begin
        #2_000_000;
        $error("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [25:0] oh(input int i);
        logic [25:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one clock; outputs are sampled on the falling edge and the
    // error / commit pulses are matched against the scoreboard.
    task automatic cycle();
        @(negedge CLOCK_50);
        if (err_valid === 1'b1) begin
            if (err_q.size() != 0) check("err_code", 32'(err_code), 32'(err_q.pop_front()));
            else check("unexpected_err_valid", 32'(err_valid), 32'd0);
        end
        if (pair_done === 1'b1) begin
            if (pd_q.size() != 0) begin
                check("count_during_commit", 32'(pair_count), 32'(pd_q.pop_front()));
                check("busy_during_commit", 32'(busy), 32'd1);
            end else begin
                check("unexpected_pair_done", 32'(pair_done), 32'd0);
            end
        end
    endtask

    task automatic strobe(input logic [25:0] v);
        letter_in    = v;
        letter_valid = 1'b1;
        cycle();
        letter_valid = 1'b0;
        letter_in    = '0;
    endtask

    task automatic lookup(input string tag, input logic [25:0] f, input logic [25:0] r,
                          input logic [25:0] ef, input logic [25:0] er);
        fwd_in = f;
        rev_in = r;
        fwd_q.push_back(ef);
        rev_q.push_back(er);
        cycle();
        check({tag, "_fwd"}, 32'(fwd_out), 32'(fwd_q.pop_front()));
        check({tag, "_rev"}, 32'(rev_out), 32'(rev_q.pop_front()));
    endtask

    task automatic commit_pair(input int a, input int b);
        pd_q.push_back(exp_count);
        strobe(oh(a));
        check("pending_first", 32'(pending_letter), 32'(oh(a)));
        strobe(oh(b));
        cycle();
        exp_count++;
        check("count_after_commit", 32'(pair_count), 32'(exp_count));
        check("pending_after_commit", 32'(pending_letter), 32'd0);
        check("commit_seen", 32'(pd_q.size()), 32'd0);
    endtask

    task automatic do_clear();
        int n;
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        n = (busy === 1'b1) ? 1 : 0;
        for (int i = 0; i < 40 && busy === 1'b1; i++) begin
            if (i == 4) clear = 1'b1;
            cycle();
            clear = 1'b0;
            if (busy === 1'b1) n++;
        end
        exp_count = 0;
        check("clear_busy_cycles", 32'(n), 32'd26);
        check("clear_count", 32'(pair_count), 32'd0);
        check("clear_err_code", 32'(err_code), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"},      32'(busy), 32'd0);
        check({tag, "_pending"},   32'(pending_letter), 32'd0);
        check({tag, "_count"},     32'(pair_count), 32'd0);
        check({tag, "_pair_done"}, 32'(pair_done), 32'd0);
        check({tag, "_err_valid"}, 32'(err_valid), 32'd0);
        check({tag, "_err_code"},  32'(err_code), 32'd0);
        check({tag, "_fwd_out"},   32'(fwd_out), 32'd0);
        check({tag, "_rev_out"},   32'(rev_out), 32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        cfg_mode     = 1'b0;
        clear        = 1'b0;
        letter_in    = '0;
        letter_valid = 1'b0;
        fwd_in       = oh(3);
        rev_in       = oh(4);

        // Reset state.
        cycle();
        cycle();
        check_reset_values("reset");
        reset = 1'b0;

        // Identity map and invalid lookup inputs.
        lookup("identity", oh(0), oh(25), oh(0), oh(25));
        check("idle_count", 32'(pair_count), 32'd0);
        check("idle_err_code", 32'(err_code), 32'd0);
        lookup("bad_lookup", 26'h0, 26'h3, 26'h0, 26'h0);

        // Entry ignored with cfg_mode low.
        strobe(oh(1));
        check("cfg_off_pending", 32'(pending_letter), 32'd0);

        // A, A -> same-letter error.
        cfg_mode = 1'b1;
        strobe(oh(0));
        check("pending_A", 32'(pending_letter), 32'(oh(0)));
        err_q.push_back(E_SAME);
        strobe(oh(0));
        check("same_pending", 32'(pending_letter), 32'd0);

        // A-Q pair, then both lookup directions.
        commit_pair(0, 16);
        lookup("pair_AQ", oh(0), oh(16), oh(16), oh(0));

        // A already plugged.
        err_q.push_back(E_PLUGGED);
        strobe(oh(0));
        check("plugged_pending", 32'(pending_letter), 32'd0);

        // Not one-hot, then code held with no further pulse.
        err_q.push_back(E_ONEHOT);
        strobe(26'h3);
        check("onehot_pending", 32'(pending_letter), 32'd0);
        cycle();
        check("err_valid_pulse", 32'(err_valid), 32'd0);
        check("err_code_held", 32'(err_code), 32'(E_ONEHOT));

        // Second-letter errors abandon the pair.
        strobe(oh(1));
        err_q.push_back(E_PLUGGED);
        strobe(oh(16));
        check("second_plugged_pending", 32'(pending_letter), 32'd0);
        strobe(oh(1));
        err_q.push_back(E_ONEHOT);
        strobe(26'h5);
        check("second_onehot_pending", 32'(pending_letter), 32'd0);

        // Clear, with a re-asserted clear mid-sweep.
        do_clear();
        lookup("after_clear", oh(0), oh(16), oh(0), oh(16));

        // Fill AB..ST, then table full.
        for (int k = 0; k < 10; k++) commit_pair(2 * k, 2 * k + 1);
        check("full_count", 32'(pair_count), 32'd10);
        lookup("full_map", oh(19), oh(0), oh(18), oh(1));
        err_q.push_back(E_FULL);
        strobe(oh(20));
        check("full_count_held", 32'(pair_count), 32'd10);
        check("full_pending", 32'(pending_letter), 32'd0);

        do_clear();
        lookup("cleared_full", oh(0), oh(19), oh(0), oh(19));

        // First letter then cfg_mode drop: silent abandon.
        strobe(oh(2));
        check("pending_C", 32'(pending_letter), 32'(oh(2)));
        cfg_mode = 1'b0;
        cycle();
        check("abandon_pending", 32'(pending_letter), 32'd0);
        cfg_mode = 1'b1;
        commit_pair(2, 3);
        lookup("pair_CD", oh(2), oh(3), oh(3), oh(2));

        // Reset ten cycles into a clear sweep.
        commit_pair(24, 25);
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        repeat (9) cycle();
        check("mid_clear_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        exp_count = 0;
        check_reset_values("reset_clear");
        lookup("reset_clear_map", oh(24), oh(2), oh(24), oh(2));
        lookup("reset_clear_map2", oh(25), oh(3), oh(25), oh(3));

        // Reset while a first letter is pending.
        err_q.push_back(E_ONEHOT);
        strobe(26'h0);
        strobe(oh(4));
        check("pending_E", 32'(pending_letter), 32'(oh(4)));
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check_reset_values("reset_first");
        commit_pair(4, 5);
        lookup("pair_EF", oh(4), oh(5), oh(5), oh(4));

        check("err_queue_drained", 32'(err_q.size()), 32'd0);
        check("commit_queue_drained", 32'(pd_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
